// File: rtl/ysyx_22040759_dmem_resp.sv
// Multi-cycle data SRAM responder for the core's load/store path.
// Takes one request at a time on a valid/ready channel and answers on a second
// valid/ready channel after a fixed latency. Stores commit on the accept edge.
// Loads read the array on the edge that enters the response state.
module ysyx_22040759_dmem_resp #(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned LATENCY    = 2,
    parameter logic [63:0] BASE       = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [2:0]  req_func3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned Words   = 1 << DEPTH_LOG2;
    localparam logic [63:0] Span    = 64'(Words) << 3;
    localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    logic [63:0] mem [Words];

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wen_q, wen_d;
    logic [2:0]  func3_q, func3_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic                  accept;
    logic [DEPTH_LOG2-1:0] req_idx, lat_idx;
    logic [64:0]           req_rsp, lat_rsp;
    logic                  wr_en;
    logic [7:0]            wr_mask;
    logic [63:0]           wr_data;

    // Returns {err, rdata} for a request against the word currently holding its address.
    function automatic logic [64:0] build_rsp(input logic        wen,
                                              input logic [2:0]  f3,
                                              input logic [63:0] addr,
                                              input logic [63:0] word);
        logic        in_range;
        logic        misal;
        logic        illegal;
        logic        err;
        logic [63:0] sh;
        logic [63:0] data;
        in_range = (addr >= BASE) && ((addr - BASE) < Span);
        case (f3[1:0])
            2'd0:    misal = 1'b0;
            2'd1:    misal = addr[0];
            2'd2:    misal = |addr[1:0];
            default: misal = |addr[2:0];
        endcase
        illegal = wen ? f3[2] : (f3 == 3'd7);
        err     = !in_range || misal || illegal;
        sh      = word >> {addr[2:0], 3'b000};
        case (f3)
            3'd0:    data = {{56{sh[7]}}, sh[7:0]};
            3'd1:    data = {{48{sh[15]}}, sh[15:0]};
            3'd2:    data = {{32{sh[31]}}, sh[31:0]};
            3'd3:    data = sh;
            3'd4:    data = {56'd0, sh[7:0]};
            3'd5:    data = {48'd0, sh[15:0]};
            3'd6:    data = {32'd0, sh[31:0]};
            default: data = 64'd0;
        endcase
        if (wen || err) begin
            data = 64'd0;
        end
        return {err, data};
    endfunction

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign accept    = req_valid && req_ready;

    assign req_idx = DEPTH_LOG2'((req_addr - BASE) >> 3);
    assign lat_idx = DEPTH_LOG2'((addr_q - BASE) >> 3);
    assign req_rsp = build_rsp(req_wen, req_func3, req_addr, mem[req_idx]);
    assign lat_rsp = build_rsp(wen_q, func3_q, addr_q, mem[lat_idx]);

    // Store lane enables and lane-placed data for the accept edge.
    always_comb begin
        case (req_func3[1:0])
            2'd0:    wr_mask = 8'h01;
            2'd1:    wr_mask = 8'h03;
            2'd2:    wr_mask = 8'h0f;
            default: wr_mask = 8'hff;
        endcase
        wr_mask = wr_mask << req_addr[2:0];
        wr_data = req_wdata << {req_addr[2:0], 3'b000};
        wr_en   = accept && req_wen && !req_rsp[64];
    end

    // Storage is never reset; only legal stores touch it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (wr_mask[b]) begin
                    mem[req_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    // Next-state: accept, count down the latency, hold the response until taken.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wen_d   = wen_q;
        func3_d = func3_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    wen_d   = req_wen;
                    func3_d = req_func3;
                    addr_d  = req_addr;
                    if (LATENCY == 1) begin
                        state_d          = StResp;
                        cnt_d            = 4'd0;
                        {err_d, rdata_d} = req_rsp;
                    end else begin
                        state_d = StBusy;
                        cnt_d   = CntInit;
                    end
                end
            end
            StBusy: begin
                cnt_d = cnt_q - 4'd1;
                // Counter reaches zero on this edge: the response becomes visible next cycle.
                if (cnt_q <= 4'd1) begin
                    state_d          = StResp;
                    cnt_d            = 4'd0;
                    {err_d, rdata_d} = lat_rsp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and response registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            wen_q   <= 1'b0;
            func3_q <= 3'd0;
            addr_q  <= 64'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            func3_q <= func3_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule
